// File: rtl/uart_tx_framer.sv
// Purpose : UART serial transmitter; 4-entry byte FIFO, MSB-first framing, optional parity, 1/2 stop bits, RTS/CTS.
// Latency : byte pushed at edge E into an empty FIFO while idle and clear to send -> start bit on DATA_OUT after edge E+1.
// Backpr. : DATA_READY drops while the FIFO holds 4 bytes; CTS gates only the start of a frame, never truncates one.
//
// Ports:
//   Clock, Reset          single clock, synchronous active-high reset
//   DATA_IN/DATA_VALID    byte write request; accepted when DATA_READY is high
//   DATA_READY            FIFO not full (combinational from the occupancy count)
//   CTS / RTS             flow control toward the receiver (active only when mode bit [4] is set)
//   DATA_OUT              serial line, idle high
//   BUSY                  high while a frame is on the line
// Mode byte uses the receiver's encoding so both link ends share one constant:
//   [7:6] baud select, [5] 1=one stop bit, [4] flow control, [3:2] data bits 5..8, [1] odd parity, [0] parity enable
module uart_tx_framer #(
   parameter logic [7:0]  modos_de_operacao = 8'h00,
   parameter int unsigned div_override      = 0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] DATA_IN,
   input  logic       DATA_VALID,
   output logic       DATA_READY,
   input  logic       CTS,
   output logic       RTS,
   output logic       DATA_OUT,
   output logic       BUSY
);

   // ---------------------------------------------------------------
   // Static configuration decoded from the mode byte
   // ---------------------------------------------------------------
   localparam logic [1:0]  BAUD_SEL  = modos_de_operacao[7:6];
   localparam logic        ONE_STOP  = modos_de_operacao[5];
   localparam logic        FLOW_EN   = modos_de_operacao[4];
   localparam logic [1:0]  DBITS_SEL = modos_de_operacao[3:2];
   localparam logic        PAR_ODD   = modos_de_operacao[1];
   localparam logic        PAR_EN    = modos_de_operacao[0];

   localparam logic [15:0] TABLE_DIV = (BAUD_SEL == 2'b00) ? 16'd10416 :
                                       (BAUD_SEL == 2'b01) ? 16'd5208  :
                                       (BAUD_SEL == 2'b10) ? 16'd2604  : 16'd868;
   localparam logic [15:0] PERIOD    = (div_override != 0) ? 16'(div_override) : TABLE_DIV;
   localparam logic [15:0] CNT_LAST  = PERIOD - 16'd1;
   localparam logic [3:0]  NBITS     = 4'd5 + {2'b00, DBITS_SEL};
   localparam logic [3:0]  LAST_BIT  = NBITS - 4'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   // ---------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------
   logic [7:0]  r_mem [4];
   logic [1:0]  r_wp;
   logic [1:0]  r_rp;
   logic [2:0]  r_count;

   // ---------------------------------------------------------------
   // Framer state
   // ---------------------------------------------------------------
   state_t      r_state;
   logic [15:0] r_cnt;
   logic [3:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_par;
   logic        r_data_out;
   logic        r_busy;
   logic        r_rts;

   logic        w_push;
   logic        w_pop;
   logic        w_start_ok;
   logic        w_last;
   logic        w_eof;
   logic        w_busy_nxt;
   logic [2:0]  w_count_nxt;
   logic [7:0]  w_head;

   assign DATA_READY  = (r_count != 3'd4);
   assign w_push      = DATA_VALID && DATA_READY;
   assign w_head      = r_mem[r_rp];
   assign w_start_ok  = (r_count != 3'd0) && (!FLOW_EN || CTS);
   assign w_last      = (r_cnt == CNT_LAST);
   // Final edge of a frame: last period of the last stop bit.
   assign w_eof       = w_last && (((r_state == S_STOP1) && ONE_STOP) || (r_state == S_STOP2));
   // A byte leaves the FIFO either from idle or chained straight onto the previous frame.
   assign w_pop       = w_start_ok && ((r_state == S_IDLE) || w_eof);
   assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
   assign w_busy_nxt  = (r_state == S_IDLE) ? w_start_ok : !(w_eof && !w_start_ok);

   assign DATA_OUT    = r_data_out;
   assign BUSY        = r_busy;
   assign RTS         = r_rts;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_wp    <= 2'd0;
         r_rp    <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= DATA_IN;
            r_wp        <= r_wp + 2'd1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 2'd1;
         end
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 16'd0;
         r_bit      <= 4'd0;
         r_shift    <= 8'd0;
         r_par      <= 1'b0;
         r_data_out <= 1'b1;
         r_busy     <= 1'b0;
         r_rts      <= 1'b0;
      end else begin
         // RTS registered from the next-cycle FIFO occupancy and busy state.
         r_rts <= FLOW_EN && ((w_count_nxt != 3'd0) || w_busy_nxt);

         if (r_state == S_IDLE) begin
            r_cnt <= 16'd0;
            if (w_start_ok) begin
               r_shift    <= w_head;
               r_par      <= 1'b0;
               r_state    <= S_START;
               r_data_out <= 1'b0;
               r_busy     <= 1'b1;
            end
         end else if (!w_last) begin
            r_cnt <= r_cnt + 16'd1;
         end else begin
            r_cnt <= 16'd0;
            case (r_state)
               S_START: begin
                  r_state    <= S_DATA;
                  r_data_out <= r_shift[7];
                  r_par      <= r_par ^ r_shift[7];
                  r_shift    <= {r_shift[6:0], 1'b0};
                  r_bit      <= 4'd0;
               end
               S_DATA: begin
                  if (r_bit == LAST_BIT) begin
                     if (PAR_EN) begin
                        r_state    <= S_PARITY;
                        // Accumulator already holds every sent data bit.
                        r_data_out <= r_par ^ PAR_ODD;
                     end else begin
                        r_state    <= S_STOP1;
                        r_data_out <= 1'b1;
                     end
                  end else begin
                     r_data_out <= r_shift[7];
                     r_par      <= r_par ^ r_shift[7];
                     r_shift    <= {r_shift[6:0], 1'b0};
                     r_bit      <= r_bit + 4'd1;
                  end
               end
               S_PARITY: begin
                  r_state    <= S_STOP1;
                  r_data_out <= 1'b1;
               end
               S_STOP1, S_STOP2: begin
                  if ((r_state == S_STOP1) && !ONE_STOP) begin
                     r_state    <= S_STOP2;
                     r_data_out <= 1'b1;
                  end else if (w_start_ok) begin
                     // Next byte chained with no idle gap.
                     r_shift    <= w_head;
                     r_par      <= 1'b0;
                     r_state    <= S_START;
                     r_data_out <= 1'b0;
                     r_busy     <= 1'b1;
                  end else begin
                     r_state    <= S_IDLE;
                     r_data_out <= 1'b1;
                     r_busy     <= 1'b0;
                  end
               end
               default: begin
                  r_state    <= S_IDLE;
                  r_data_out <= 1'b1;
                  r_busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
